frodo_mac_seq: RTL
==================

Name: frodo_mac_seq

Overview:
- Initiator-side sequencer for the team's 16-bit Frodo multiply-accumulate unit (a*b + c mod 2^16, 2-cycle en-to-result).
- Takes a stream of (A element, small signed S element) pairs and drives the MAC one element at a time, feeding each result back as the next addend.
- Returns one LEN-term inner product init_c + sum(a_i*s_i) mod 2^16.
- Sits between operand memories/sampler and the MAC in the matrix-vector datapath.

Parameters:
- LEN, 640, number of products per inner product (Frodo-640 n); legal range 1..2^CNT_W.
- CNT_W, 10, element counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin inner product; sampled only in IDLE
- init_c  in  16  initial accumulator value, captured with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a  in  16  unsigned A element
- in_b  in  8  signed S element; legal range -16..15
- mac_en  out  1  one-cycle MAC issue strobe
- mac_a  out  16  MAC multiplier
- mac_b  out  8  MAC multiplicand
- mac_c  out  16  MAC addend
- mac_done  in  1  MAC done; ignored, because it may stay high after the first operation
- mac_result  in  16  MAC result register
- out_valid  out  1  inner product valid
- out_ready  in  1  consumer accepts result
- out_data  out  16  inner product
- busy  out  1  high in every state except IDLE
- err  out  1  sticky illegal-in_b flag; cleared by start or rst

Behaviour:
- Reset (async, rst high): state=IDLE; acc, cnt, opa, opb=0; all outputs 0, including mac_en, in_ready, out_valid, err. Reset mid-operation abandons the computation; no partial result is ever presented.
- MAC contract:
  - Operands must be stable in the mac_en cycle and the following cycle.
  - mac_result is valid in the second cycle after the mac_en cycle.
  - The sequencer times this with its own FSM; it never uses mac_done.
- mac_a/mac_b/mac_c are always driven from registers opa/opb/acc, so they are stable by construction.
- FSM:
  - IDLE: on start -> acc<=init_c, cnt<=0, err<=0, go FETCH. start in any other state is ignored.
  - FETCH: in_ready=1. On handshake: opa<=in_a. If in_b[7:5] != {3{in_b[4]}}, err<=1. opb<={{3{in_b[4]}},in_b[4:0]} (always sign-extended from bit 4). Go ISSUE.
  - ISSUE: mac_en=1 -> WAIT.
  - WAIT: mac_en=0 -> COLLECT.
  - COLLECT: acc<=mac_result, cnt<=cnt+1. If cnt==LEN-1 -> OUT, else -> FETCH.
  - OUT: out_valid=1, out_data=acc. On out_ready -> IDLE. out_data is held stable while out_valid & !out_ready.
- Timing:
  - Throughput 4 cycles/element with in_valid held high.
  - Latency from start to out_valid = 4*LEN+1 cycles minimum.
- Arithmetic: 16-bit, mod 2^16; wrap is silent (no overflow flag).
- in_ready is low outside FETCH; in_valid outside FETCH is ignored, with no data loss if the producer holds it.
- LEN=1: single pass FETCH->...->COLLECT->OUT.
- out_ready high before OUT has no effect; the OUT->IDLE edge consumes exactly one result.

Decomposition:
- Shared package frodo_pkg:
  - FSM state encoding (IDLE, FETCH, ISSUE, WAIT, COLLECT, OUT)
  - constants Q_W=16, B_W=8, B_SIGN_BIT=4, MAC_LAT=2
- No sub-module: the MAC is instantiated alongside the sequencer by the datapath top, not inside it.

Test Plan (bench connects the team's 16-bit Frodo MAC to the mac_* ports):
1. LEN=4, init_c=0, pairs (1,1),(2,2),(3,3),(4,4), in_valid always high -> out_data=0x001E; out_valid first high 17 cycles after start; err=0.
2. LEN=1, init_c=100, a=7, b=0xF0 (-16) -> out_data=0xFFF4 (-12).
3. LEN=2, init_c=0xFFFF, pairs (1,1),(0x8000,2) -> out_data=0x0000 (both wraps silent).
4. LEN=1, b=0x20 (illegal) -> err=1 and held through OUT; opb=0x00; out_data=init_c. Next start clears err.
5. Backpressure: out_ready low 5 cycles in OUT, in_valid toggling, start pulsed -> out_data stable, in_ready=0, start ignored. Single IDLE return when out_ready rises.
6. rst asserted during WAIT of element 3 -> all outputs 0 immediately; mac_en never pulses again until new start. Fresh LEN=4 run reproduces scenario 1's value.

Source files
------------

// File: rtl/frodo_pkg.sv
//==============================================================================
// Package : frodo_pkg
// Desc    : Shared types, widths and S-element helpers for the Frodo MAC path.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package frodo_pkg;

  localparam int Q_W        = 16;
  localparam int B_W        = 8;
  localparam int B_SIGN_BIT = 4;
  localparam int MAC_LAT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COLLECT = 3'd4,
    ST_OUT     = 3'd5
  } state_t;

  // S elements are 5-bit signed values carried in an 8-bit field
  function automatic logic b_illegal(input logic [B_W-1:0] b);
    return b[B_W-1:B_SIGN_BIT+1] != {(B_W-B_SIGN_BIT-1){b[B_SIGN_BIT]}};
  endfunction

  function automatic logic [B_W-1:0] b_sext(input logic [B_W-1:0] b);
    return {{(B_W-B_SIGN_BIT-1){b[B_SIGN_BIT]}}, b[B_SIGN_BIT:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/frodo_mac_seq.sv
//==============================================================================
// Module : frodo_mac_seq
// Desc   : Drives an external 2-cycle MAC to produce one LEN-term inner product.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module frodo_mac_seq
  import frodo_pkg::*;
#(
  parameter int LEN   = 640,
  parameter int CNT_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Q_W-1:0] init_c,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  output logic           mac_en,
  output logic [Q_W-1:0] mac_a,
  output logic [B_W-1:0] mac_b,
  output logic [Q_W-1:0] mac_c,
  input  logic           mac_done,
  input  logic [Q_W-1:0] mac_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] out_data,
  output logic           busy,
  output logic           err
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LEN - 1);

  // ISSUE and WAIT together cover exactly two cycles of MAC latency
  if (MAC_LAT != 2) begin : g_lat_guard
    $error("frodo_mac_seq sequencing assumes a 2-cycle MAC");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [Q_W-1:0]   r_acc;
  logic [Q_W-1:0]   r_opa;
  logic [B_W-1:0]   r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_fetch_hs;
  logic             w_last;
  logic             w_unused_mac_done;

  assign w_fetch_hs        = (r_state == ST_FETCH) && in_valid;
  assign w_last            = (r_cnt == c_LAST);
  assign w_unused_mac_done = mac_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_FETCH;
      ST_FETCH:   if (in_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_WAIT;
      ST_WAIT:    w_state_nxt = ST_COLLECT;
      ST_COLLECT: w_state_nxt = w_last ? ST_OUT : ST_FETCH;
      ST_OUT:     if (out_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_opa <= '0;
      r_opb <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_acc <= init_c;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (w_fetch_hs) begin
        r_opa <= in_a;
        r_opb <= b_sext(in_b);
        if (b_illegal(in_b)) r_err <= 1'b1;
      end
      // mac_result is valid in COLLECT, two cycles after the ISSUE strobe
      if (r_state == ST_COLLECT) begin
        r_acc <= mac_result;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == ST_FETCH);
  assign mac_en    = (r_state == ST_ISSUE);
  assign out_valid = (r_state == ST_OUT);
  assign busy      = (r_state != ST_IDLE);
  assign mac_a     = r_opa;
  assign mac_b     = r_opb;
  assign mac_c     = r_acc;
  assign out_data  = r_acc;
  assign err       = r_err;

endmodule

`default_nettype wire
